// File: rtl/cam_pkg.sv
// ----------------------------------------------------------------------------
// cam_pkg : shared encodings, FSM state type and RGB565 field widths
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cam_pkg;

  localparam int MODE_RGB332 = 0;
  localparam int MODE_RGB444 = 1;
  localparam int MODE_GRAY8  = 2;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/cam_px_convert.sv
// ----------------------------------------------------------------------------
// cam_px_convert : combinational RGB565 -> RGB332 / RGB444 / 8-bit gray
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_px_convert
  import cam_pkg::*;
#(
  parameter int MODE = MODE_RGB332,
  parameter int DW   = 8
) (
  input  logic [15:0]   rgb565,
  output logic [DW-1:0] px
);

  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;
  logic [7:0]     r8;
  logic [7:0]     g8;
  logic [7:0]     b8;
  logic [9:0]     sum;

  assign {r, g, b} = rgb565;

  // Bit replication expands each channel to the full 0..255 range.
  assign r8  = {r, r[4:2]};
  assign g8  = {g, g[5:4]};
  assign b8  = {b, b[4:2]};
  assign sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};

  always_comb begin
    px = '0;
    case (MODE)
      MODE_RGB332: px = DW'({r[4:2], g[5:3], b[4:3]});
      MODE_RGB444: px = DW'({r[4:1], g[5:2], b[4:1]});
      default:     px = DW'(sum >> 2);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cam_capture.sv
// ----------------------------------------------------------------------------
// cam_capture : camera byte stream -> pixel memory writes (optional 2x decimation
//               via CAM_CAPTURE_DECIM_EN)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_capture
  import cam_pkg::*;
#(
  parameter int AW    = 17,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int MODE  = MODE_RGB332,
  parameter int DW    = 8
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  localparam logic [AW-1:0] PX_TOTAL = AW'(IMG_W * IMG_H);

  cap_state_t    state;
  cap_state_t    state_nxt;
  logic [AW-1:0] addr;
  logic          phase;
  logic [7:0]    hi_byte;
  logic [DW-1:0] conv_px;
  logic          start;
  logic          capture;
  logic          px_done;
  logic          keep;

  cam_px_convert #(
    .MODE (MODE),
    .DW   (DW)
  ) u_convert (
    .rgb565 ({hi_byte, px_data}),
    .px     (conv_px)
  );

  assign start   = (state == S_ARMED) && !vsync;
  assign capture = (state == S_CAPTURE);
  assign px_done = capture && href && phase;

  always_ff @(posedge pclk) begin
    if (rst) state <= S_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:    if (vsync)  state_nxt = S_ARMED;
      S_ARMED:   if (!vsync) state_nxt = S_CAPTURE;
      S_CAPTURE: if (vsync)  state_nxt = S_ARMED;
      default:   state_nxt = S_SYNC;
    endcase
  end

`ifdef CAM_CAPTURE_DECIM_EN
  logic col_odd;
  logic row_odd;
  logic href_d;

  // Only parity matters: a line ends on every falling edge of href.
  always_ff @(posedge pclk) begin
    if (rst) begin
      col_odd <= 1'b0;
      row_odd <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      href_d <= href;
      if (start) begin
        col_odd <= 1'b0;
        row_odd <= 1'b0;
      end else if (capture) begin
        if (!href)      col_odd <= 1'b0;
        else if (phase) col_odd <= ~col_odd;
        if (href_d && !href) row_odd <= ~row_odd;
      end
    end
  end

  assign keep = !col_odd && !row_odd;
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      addr        <= '0;
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      px_wr      <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        addr  <= '0;
        phase <= 1'b0;
      end else if (capture) begin
        if (vsync) frame_done <= 1'b1;
        if (!href) begin
          phase <= 1'b0;
        end else if (!phase) begin
          hi_byte <= px_data;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (keep) begin
            if (addr == PX_TOTAL) begin
              overflow <= 1'b1;
            end else begin
              px_wr       <= 1'b1;
              mem_px_addr <= addr;
              mem_px_data <= conv_px;
              addr        <= addr + 1'b1;
            end
          end
        end
      end
    end
  end

  wire unused_px_done = px_done;

endmodule

`default_nettype wire

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: three instances (MODE 0/1/2) share one stimulus and a
// frame-level expected-write queue built from the byte stream that is sent.
`default_nettype none

module tb_cam_capture;

`ifdef CAM_CAPTURE_DECIM_EN
  localparam int IMG_W    = 40;
  localparam int IMG_H    = 30;
  localparam int SC       = 2;
  localparam int EXP_FULL = 1200;
  localparam int EXP_321  = 40;
`else
  localparam int IMG_W    = 160;
  localparam int IMG_H    = 120;
  localparam int SC       = 1;
  localparam int EXP_FULL = 19200;
  localparam int EXP_321  = 320;
`endif
  localparam int TOTAL = IMG_W * IMG_H;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] px_data = 8'h00;

  always #5 pclk = ~pclk;

  logic [16:0] a0, a1, a2;
  logic [7:0]  d0, d2;
  logic [11:0] d1;
  logic        wr0, wr1, wr2, fd0, fd1, fd2, ov0, ov1, ov2;

  cam_capture #(.AW(17), .IMG_W(IMG_W), .IMG_H(IMG_H), .MODE(0), .DW(8)) u_dut0 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .mem_px_addr(a0), .mem_px_data(d0), .px_wr(wr0), .frame_done(fd0), .overflow(ov0));
  cam_capture #(.AW(17), .IMG_W(IMG_W), .IMG_H(IMG_H), .MODE(1), .DW(12)) u_dut1 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .mem_px_addr(a1), .mem_px_data(d1), .px_wr(wr1), .frame_done(fd1), .overflow(ov1));
  cam_capture #(.AW(17), .IMG_W(IMG_W), .IMG_H(IMG_H), .MODE(2), .DW(8)) u_dut2 (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
    .mem_px_addr(a2), .mem_px_data(d2), .px_wr(wr2), .frame_done(fd2), .overflow(ov2));

  typedef struct {
    int          addr;
    logic [15:0] pix;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   rd[3] = '{0, 0, 0};
  int   wr_cnt[3] = '{0, 0, 0};
  int   last_addr[3] = '{-1, -1, -1};
  int   last_data[3] = '{-1, -1, -1};
  int   fd_cnt = 0;
  int   fd_exp = 0;
  int   ovf_exp = 0;
  int   fid = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Spec-level conversion from the channel values, using plain arithmetic.
  function automatic int conv(input int mode, input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    case (mode)
      0:       return (r / 4) * 32 + (g / 8) * 4 + (b / 8);
      1:       return (r / 2) * 256 + (g / 4) * 16 + (b / 2);
      default: return (r8 + 2 * g8 + b8) / 4;
    endcase
  endfunction

  function automatic logic [15:0] pix_of(input int f, input int l, input int p);
    return 16'((f * 7919 + l * 331 + p * 40503 + 17) & 32'hFFFF);
  endfunction

  always @(negedge pclk) begin
    logic        wv[3];
    int          av[3];
    int          dv[3];
    wv = '{wr0, wr1, wr2};
    av = '{int'(a0), int'(a1), int'(a2)};
    dv = '{int'(d0), int'(d1), int'(d2)};
    for (int k = 0; k < 3; k++) begin
      if (wv[k]) begin
        wr_cnt[k]++;
        last_addr[k] = av[k];
        last_data[k] = dv[k];
        chk($sformatf("wr_expected_m%0d", k), longint'(rd[k] < exp_q.size()), 1);
        if (rd[k] < exp_q.size()) begin
          chk($sformatf("addr_m%0d", k), av[k], exp_q[rd[k]].addr);
          chk($sformatf("data_m%0d", k), dv[k], conv(k, exp_q[rd[k]].pix));
          rd[k]++;
        end
      end
    end
    if (fd0) fd_cnt++;
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge pclk);
    #1;
    vsync   = vs;
    href    = hr;
    px_data = d;
  endtask

  // Sends one frame and queues the writes it must produce.
  task automatic frame(input int nl, input int nb, input int xb, input int red);
    int          idx;
    int          len;
    int          p;
    logic [15:0] pix;
    bit          keepit;
    idx = 0;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nl + ((xb > 0) ? 1 : 0); l++) begin
      len = (l == nl) ? xb : nb;
      for (int bi = 0; bi < len; bi++) begin
        p   = bi / 2;
        pix = (red != 0) ? 16'hF800 : pix_of(fid, l, p);
        drive(1'b0, 1'b1, (bi % 2 == 0) ? pix[15:8] : pix[7:0]);
        if (bi % 2 == 1) begin
          keepit = (SC == 1) || ((l % 2 == 0) && (p % 2 == 0));
          if (keepit) begin
            if (idx < TOTAL) exp_q.push_back('{idx, pix});
            else             ovf_exp = 1;
            idx++;
          end
        end
      end
      repeat (2) drive(1'b0, 1'b0, 8'h00);
    end
    drive(1'b1, 1'b0, 8'h00);
    fd_exp++;
    fid++;
  endtask

  task automatic settle_check(input string nm);
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_drained_m%0d", nm, k), rd[k], exp_q.size());
    chk({nm, "_frame_done"}, fd_cnt, fd_exp);
    chk({nm, "_overflow"}, ov0, ovf_exp);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_px_wr", wr0, 0);
    chk("rst_addr", a0, 0);
    chk("rst_data_m0", d0, 0);
    chk("rst_data_m1", d1, 0);
    chk("rst_frame_done", fd0, 0);
    chk("rst_overflow", ov0, 0);
    rst = 1'b0;

    // Pure red single pixel
    frame(1, 2, 0, 1);
    settle_check("red");
    chk("red_addr", last_addr[0], 0);
    chk("red_m0", last_data[0], 'hE0);
    chk("red_m1", last_data[1], 'hF00);
    chk("red_m2", last_data[2], 'h3F);

    // Full frame
    base = wr_cnt[0];
    frame(IMG_H * SC, IMG_W * SC * 2, 0, 0);
    settle_check("full");
    chk("full_count", wr_cnt[0] - base, EXP_FULL);
    chk("full_last_addr", last_addr[0], EXP_FULL - 1);

    // Next frame restarts at address 0
    frame(1, 2, 0, 0);
    settle_check("restart");
    chk("restart_addr", last_addr[0], 0);

    // Odd-length lines drop the trailing byte
    base = wr_cnt[0];
    frame(2, IMG_W * SC * 2 + 1, 0, 0);
    settle_check("odd_line");
    chk("odd_line_count", wr_cnt[0] - base, EXP_321);

    // One pixel too many
    base = wr_cnt[0];
    frame(IMG_H * SC, IMG_W * SC * 2, 2, 0);
    settle_check("ovf");
    chk("ovf_count", wr_cnt[0] - base, EXP_FULL);
    chk("ovf_flag", ov0, 1);
    frame(1, 4, 0, 0);
    settle_check("ovf_sticky");
    chk("ovf_sticky_flag", ov0, 1);

    // Reset after the first byte of a pixel
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hAA);
    @(posedge pclk);
    #1;
    rst     = 1'b1;
    px_data = 8'h55;
    @(posedge pclk);
    #1;
    rst     = 1'b0;
    ovf_exp = 0;
    base    = wr_cnt[0];
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(i * 37));
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    chk("rst_mid_no_wr", wr_cnt[0] - base, 0);
    chk("rst_mid_overflow", ov0, 0);
    frame(1, 2, 0, 0);
    settle_check("after_rst");
    chk("after_rst_addr", last_addr[0], 0);
    chk("after_rst_count", wr_cnt[0] - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter AW, default 17: width of the memory pixel address.
REQ-002 Parameter IMG_W, default 160: active pixels per line written to memory.
REQ-003 Parameter IMG_H, default 120: active lines per frame written to memory.
REQ-004 Parameter MODE, default 0: output format; 0 = RGB332, 1 = RGB444, 2 = 8-bit gray.
REQ-005 Parameter DW, default 8: output pixel width; SHALL be 12 when MODE=1 and 8 otherwise.
REQ-006 pclk  in  1: camera pixel clock, the only clock; all state on its rising edge.
REQ-007 rst  in  1: reset; synchronous and active-high.
REQ-008 vsync  in  1: frame sync, high during vertical blanking.
REQ-009 href  in  1: line valid; bytes are valid while href is high.
REQ-010 px_data  in  8: camera byte, RGB565, high byte first.
REQ-011 mem_px_addr  out  AW: write address.
REQ-012 mem_px_data  out  DW: converted pixel.
REQ-013 px_wr  out  1: one-cycle write strobe for addr/data.
REQ-014 frame_done  out  1: one-cycle pulse at the end of each captured frame.
REQ-015 overflow  out  1: sticky flag; more than IMG_W*IMG_H pixels arrived in a frame.

Function
REQ-016 FSM states: S_SYNC (wait for vsync=1), S_ARMED (wait for vsync=0), S_CAPTURE.
REQ-017 S_SYNC -> S_ARMED when vsync=1; S_ARMED -> S_CAPTURE when vsync=0; at that transition address=0 and byte phase=0.
REQ-018 In S_CAPTURE, every cycle with href=1 samples px_data and toggles the byte phase: phase 0 latches the high byte; phase 1 forms the pixel.
REQ-019 Byte phase SHALL clear whenever href=0; an odd trailing byte of a line is discarded.
REQ-020 px_wr SHALL assert exactly one cycle after the phase-1 byte is sampled, with mem_px_addr and mem_px_data valid in that same cycle.
REQ-021 After each write, address +1; no write when address has reached IMG_W*IMG_H; instead overflow is set.
REQ-022 In S_CAPTURE, vsync=1 -> frame_done pulses for one cycle, state -> S_ARMED; a pixel completed in the same cycle is still written.
REQ-023 MODE 0: data = {R[4:2], G[5:3], B[4:3]}; MODE 1: {R[4:1], G[5:2], B[4:1]}.
REQ-024 MODE 2: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}; gray = (R8 + 2*G8 + B8) >> 2, computed in a 10-bit sum with no overflow.
REQ-025 Frame start in S_SYNC/S_ARMED never writes; href is ignored outside S_CAPTURE.

Reset
REQ-026 rst=1 -> state S_SYNC, address 0, phase 0, px_wr 0, mem_px_data 0, frame_done 0, overflow 0, on the next pclk edge.
REQ-027 Reset mid-line aborts the pixel in progress with no write; capture resumes only after a full vsync high->low.

Configuration
REQ-028 Macro CAM_CAPTURE_DECIM_EN defined: 2x decimation; only even pixels of even lines (counted from frame start) are written, so the incoming frame is 2*IMG_W x 2*IMG_H.
REQ-029 Without it: every pixel is written, with no line/column counters synthesised.

Structure
REQ-030 Shared package cam_pkg SHALL hold the MODE encodings, the FSM state typedef, and the RGB565 field widths.
REQ-031 One sub-module, cam_px_convert, SHALL hold the combinational RGB565->DW conversion selected by MODE; the FSM and counters stay in cam_capture.

Verification
REQ-032 Bytes 0xF8,0x00 (pure red), MODE 0 -> one px_wr, data 0xE0, addr 0; MODE 1 -> 0xF00; MODE 2 -> 0x3F.
REQ-033 Full 160x120 frame -> 19200 px_wr, addresses 0..19199 consecutive, one frame_done, overflow 0; the next frame restarts at addr 0.
REQ-034 Line of 321 bytes (href high) -> 160 writes; the trailing byte is dropped and the next line starts at phase 0.
REQ-035 Frame with 19201 pixels -> 19200 writes, overflow=1 and held through the next frame until rst.
REQ-036 rst pulsed after the first byte of a pixel -> no px_wr; the first write after reset occurs only after vsync 1->0, at addr 0.
REQ-037 With CAM_CAPTURE_DECIM_EN, a 320x240 frame -> 19200 writes; the pixel at column 1 or on row 1 is never written.
